// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Read-only, direct-mapped cache controller. The tag/valid/data arrays live
// outside this block: the controller drives an index and reads them back
// combinationally, and writes them through a single write strobe. Misses are
// refilled one word at a time from main memory with a request/valid handshake.
// A flush sweeps every line and clears its valid bit, one line per cycle.
//
// Address split: tag = iAddr[31:INDEX_WIDTH+2], index = iAddr[INDEX_WIDTH+1:2],
// iAddr[1:0] is ignored (word granularity).
//
// Optional feature: define CACHE_STATS_EN to build saturating hit/miss
// counters. Without it oHitCount/oMissCount are constant 0 and no counter
// registers exist.
//
// Ports
//   iCLK, iRST         clock, synchronous active-high reset
//   iReq, iAddr        CPU read request and byte address
//   iFlush             one-cycle pulse requesting invalidation of all lines
//   oReady             controller can accept a request this cycle
//   oRdValid, oRdData  registered read response (one-cycle pulse)
//   oArrIndex          line index presented to the arrays
//   iArrTag/V/Data     combinational array read of line oArrIndex
//   oArrWE             array write strobe
//   oArrTag/V/Data     array write values
//   oMemReq, oMemAddr  main-memory read request, held until iMemValid
//   iMemValid/Data     main-memory response
//   oFlushDone         one-cycle pulse at the end of a flush sweep
//   oHitCount          hit statistics counter
//   oMissCount         miss statistics counter
// -----------------------------------------------------------------------------
module cache_controller #(
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iReq,
  input  logic [31:0]             iAddr,
  input  logic                    iFlush,
  output logic                    oReady,
  output logic                    oRdValid,
  output logic [DATA_WIDTH-1:0]   oRdData,
  output logic [INDEX_WIDTH-1:0]  oArrIndex,
  input  logic [29-INDEX_WIDTH:0] iArrTag,
  input  logic                    iArrV,
  input  logic [DATA_WIDTH-1:0]   iArrData,
  output logic                    oArrWE,
  output logic [29-INDEX_WIDTH:0] oArrTag,
  output logic                    oArrV,
  output logic [DATA_WIDTH-1:0]   oArrData,
  output logic                    oMemReq,
  output logic [31:0]             oMemAddr,
  input  logic                    iMemValid,
  input  logic [DATA_WIDTH-1:0]   iMemData,
  output logic                    oFlushDone,
  output logic [31:0]             oHitCount,
  output logic [31:0]             oMissCount
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REFILL  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [TAG_WIDTH-1:0]   tag_reg, tag_next;
  logic [INDEX_WIDTH-1:0] index_reg, index_next;
  logic [INDEX_WIDTH-1:0] flush_cnt_reg, flush_cnt_next;
  logic                   flush_pend_reg, flush_pend_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic [DATA_WIDTH-1:0]  rd_data_reg, rd_data_next;
  logic                   mem_req_reg, mem_req_next;
  logic [31:0]            mem_addr_reg, mem_addr_next;
  logic                   flush_done_reg, flush_done_next;
  logic                   arr_we_raw;
  logic                   hit;

  // Byte-offset bits carry no information for a word cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^iAddr[1:0];

  // Lookup result for the latched request; only meaningful in COMPARE,
  // where oArrIndex selects the latched index.
  assign hit = iArrV && (iArrTag == tag_reg);

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      // Reset lands in FLUSH so every line is invalidated before the first
      // request can be accepted; an in-flight refill is simply dropped.
      state_reg      <= FLUSH;
      tag_reg        <= '0;
      index_reg      <= '0;
      flush_cnt_reg  <= '0;
      flush_pend_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tag_reg        <= tag_next;
      index_reg      <= index_next;
      flush_cnt_reg  <= flush_cnt_next;
      flush_pend_reg <= flush_pend_next;
      rd_valid_reg   <= rd_valid_next;
      rd_data_reg    <= rd_data_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    tag_next        = tag_reg;
    index_next      = index_reg;
    flush_cnt_next  = flush_cnt_reg;
    flush_pend_next = flush_pend_reg;
    rd_valid_next   = 1'b0;
    rd_data_next    = rd_data_reg;
    mem_req_next    = mem_req_reg;
    mem_addr_next   = mem_addr_reg;
    flush_done_next = 1'b0;

    oReady     = 1'b0;
    oArrIndex  = index_reg;
    arr_we_raw = 1'b0;
    oArrTag    = tag_reg;
    oArrV      = 1'b0;
    oArrData   = iMemData;

    case (state_reg)
      IDLE: begin
        // A flush (pending or new) wins over a request. oReady is held low
        // in that case so iReq && oReady always means "accepted".
        if (flush_pend_reg || iFlush) begin
          state_next      = FLUSH;
          flush_cnt_next  = '0;
          flush_pend_next = 1'b0;
        end else begin
          oReady = 1'b1;
          if (iReq) begin
            tag_next   = iAddr[31:INDEX_WIDTH+2];
            index_next = iAddr[INDEX_WIDTH+1:2];
            state_next = COMPARE;
          end
        end
      end

      COMPARE: begin
        if (iFlush) begin
          flush_pend_next = 1'b1;
        end
        if (hit) begin
          rd_data_next  = iArrData;
          rd_valid_next = 1'b1;
          state_next    = IDLE;
        end else begin
          mem_req_next  = 1'b1;
          mem_addr_next = {tag_reg, index_reg, 2'b00};
          state_next    = REFILL;
        end
      end

      REFILL: begin
        // oMemReq/oMemAddr are registers and are not touched here, so they
        // stay stable until the response edge.
        if (iFlush) begin
          flush_pend_next = 1'b1;
        end
        if (mem_req_reg && iMemValid) begin
          arr_we_raw    = 1'b1;
          oArrTag       = tag_reg;
          oArrV         = 1'b1;
          oArrData      = iMemData;
          rd_data_next  = iMemData;
          rd_valid_next = 1'b1;
          mem_req_next  = 1'b0;
          state_next    = IDLE;
        end
      end

      FLUSH: begin
        // iFlush is deliberately ignored here: the sweep already covers it.
        oArrIndex  = flush_cnt_reg;
        arr_we_raw = 1'b1;
        oArrV      = 1'b0;
        if (flush_cnt_reg == LAST_INDEX) begin
          // Leave the counter parked at the last index; it is re-armed to 0
          // only when a new flush is entered from IDLE.
          flush_done_next = 1'b1;
          state_next      = IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = FLUSH;
      end
    endcase
  end

  // The write strobe is suppressed while reset is asserted so that a refill
  // response coinciding with reset never reaches the arrays.
  assign oArrWE     = arr_we_raw && !iRST;
  assign oRdValid   = rd_valid_reg;
  assign oRdData    = rd_data_reg;
  assign oMemReq    = mem_req_reg;
  assign oMemAddr   = mem_addr_reg;
  assign oFlushDone = flush_done_reg;

  // ---------------------------------------------------------------------------
  // Hit/miss statistics
  // ---------------------------------------------------------------------------
`ifdef CACHE_STATS_EN
  // Slot 0 counts hits, slot 1 counts misses. Each saturates at all-ones and
  // is cleared only by reset.
  logic [1:0]  stat_inc;
  logic [31:0] stat_cnt_reg [2];

  assign stat_inc[0] = (state_reg == COMPARE) && hit;
  assign stat_inc[1] = (state_reg == COMPARE) && !hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          stat_cnt_reg[gi] <= '0;
        end else if (stat_inc[gi] && (stat_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign oHitCount  = stat_cnt_reg[0];
  assign oMissCount = stat_cnt_reg[1];
`else
  assign oHitCount  = '0;
  assign oMissCount = '0;
`endif

endmodule
